// File: rtl/matrix_scan_controller.sv
// Column-multiplexed scanner for the 5x7 LED matrix with page scheduling.
// Optional macro BRIGHTNESS_PWM_EN adds a per-frame brightness window.
module matrix_scan_controller #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int PAGE_TICKS   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [1:0] brightness,
`endif
    input  logic [6:0] level_col_1,
    input  logic [6:0] level_col_0,
    input  logic [6:0] alert_col_1,
    input  logic [6:0] alert_col_0,
    input  logic       alert_req,
    output logic [4:0] col_sel_n,
    output logic [6:0] rows,
    output logic       page,
    output logic       frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int PW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    localparam logic [PW-1:0] PCNT_MAX = PW'(PAGE_TICKS - 1);

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] pcnt_q;
    logic          page_q;
    logic          alt_q;
    logic [6:0]    snap1_q, snap1_d;
    logic [6:0]    snap0_q, snap0_d;
    logic [4:0]    col_sel_n_q;
    logic [6:0]    rows_q;
    logic          frame_tick_q;
    logic          cap;
    logic          drive;
    logic          in_win;
    logic          end_slot;
    logic          frame_end;
`ifdef BRIGHTNESS_PWM_EN
    localparam int DRIVE_LEN = SCAN_DIV - BLANK_CYCLES;
    logic [1:0]    bri_q, bri_d;
    int            lim;
`endif

    assign col_sel_n  = col_sel_n_q;
    assign rows       = rows_q;
    assign page       = page_q;
    assign frame_tick = frame_tick_q;

    // Snapshot capture at frame start and slot/drive-window decode.
    always_comb begin
        cap       = (idx_q == 3'd0) && (cnt_q == '0);
        snap1_d   = snap1_q;
        snap0_d   = snap0_q;
        if (cap) begin
            snap1_d = page_q ? alert_col_1 : level_col_1;
            snap0_d = page_q ? alert_col_0 : level_col_0;
        end
`ifdef BRIGHTNESS_PWM_EN
        bri_d  = cap ? brightness : bri_q;
        lim    = BLANK_CYCLES + (DRIVE_LEN * (int'(bri_d) + 1)) / 4;
        in_win = int'(cnt_q) < lim;
`else
        in_win = 1'b1;
`endif
        drive     = (cnt_q >= BLANK_C) && in_win;
        end_slot  = (cnt_q == CNT_MAX);
        frame_end = end_slot && (idx_q == 3'd4);
    end

    // Scan FSM: counters, snapshot, page scheduling and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            page_q       <= 1'b0;
            alt_q        <= 1'b0;
            snap1_q      <= '0;
            snap0_q      <= '0;
            col_sel_n_q  <= 5'b11111;
            rows_q       <= 7'h7F;
            frame_tick_q <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
            bri_q        <= 2'd3;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q        <= '0;
                    cnt_q        <= '0;
                    pcnt_q       <= '0;
                    page_q       <= 1'b0;
                    alt_q        <= 1'b0;
                    col_sel_n_q  <= 5'b11111;
                    rows_q       <= 7'h7F;
                    frame_tick_q <= 1'b0;
                    if (enable) state_q <= SCAN;
                end
                SCAN: begin
                    if (!enable) begin
                        state_q      <= IDLE;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        pcnt_q       <= '0;
                        page_q       <= 1'b0;
                        alt_q        <= 1'b0;
                        col_sel_n_q  <= 5'b11111;
                        rows_q       <= 7'h7F;
                        frame_tick_q <= 1'b0;
                    end else begin
                        snap1_q <= snap1_d;
                        snap0_q <= snap0_d;
`ifdef BRIGHTNESS_PWM_EN
                        bri_q   <= bri_d;
`endif
                        if (drive) begin
                            col_sel_n_q <= ~(5'b00001 << idx_q);
                            rows_q <= (idx_q == 3'd0 || idx_q == 3'd4)
                                      ? snap1_d : snap0_d;
                        end else begin
                            col_sel_n_q <= 5'b11111;
                            rows_q      <= 7'h7F;
                        end
                        frame_tick_q <= frame_end;
                        if (end_slot) begin
                            cnt_q <= '0;
                            idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (frame_end) begin
                            if (!alert_req) begin
                                page_q <= 1'b0;
                                pcnt_q <= '0;
                                alt_q  <= 1'b0;
                            end else if (!alt_q) begin
                                page_q <= 1'b1;
                                pcnt_q <= '0;
                                alt_q  <= 1'b1;
                            end else if (pcnt_q == PCNT_MAX) begin
                                page_q <= ~page_q;
                                pcnt_q <= '0;
                            end else begin
                                pcnt_q <= pcnt_q + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed, table-driven bench for matrix_scan_controller.
// Build with BRIGHTNESS_PWM_EN to also exercise the brightness window.
module tb_matrix_scan_controller;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int PT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [6:0] level_col_1, level_col_0;
    logic [6:0] alert_col_1, alert_col_0;
    logic       alert_req;
    logic [4:0] col_sel_n;
    logic [6:0] rows;
    logic       page;
    logic       frame_tick;
`ifdef BRIGHTNESS_PWM_EN
    logic [1:0] brightness = 2'd3;
`endif

    matrix_scan_controller #(
        .SCAN_DIV(SD), .BLANK_CYCLES(BC), .PAGE_TICKS(PT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
`ifdef BRIGHTNESS_PWM_EN
        .brightness(brightness),
`endif
        .level_col_1(level_col_1), .level_col_0(level_col_0),
        .alert_col_1(alert_col_1), .alert_col_0(alert_col_0),
        .alert_req(alert_req),
        .col_sel_n(col_sel_n), .rows(rows),
        .page(page), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [6:0] lvl0;
        logic       areq;
        logic [4:0] col;
        logic [6:0] rws;
        logic       tick;
        logic       pg;
    } vec_t;

    vec_t vecs [32];
    int   nvec;
    int   k;
    int   ticks;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Edge k is counted from the edge that first samples enable=1 (k=0).
    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        if (frame_tick) ticks++;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s k=%0d: got %0h expected %0h", nm, k, act, exp);
    endtask

    task automatic check_out(input string tag, input logic [4:0] c,
                             input logic [6:0] r, input logic t,
                             input logic p);
        check({tag, ".col_sel_n"}, 32'(col_sel_n), 32'(c));
        check({tag, ".rows"}, 32'(rows), 32'(r));
        check({tag, ".frame_tick"}, 32'(frame_tick), 32'(t));
        check({tag, ".page"}, 32'(page), 32'(p));
    endtask

    task automatic start(input logic areq);
        rst = 1'b1;
        enable = 1'b0;
        alert_req = areq;
        level_col_1 = 7'h01;
        level_col_0 = 7'h3E;
        alert_col_1 = 7'h55;
        alert_col_0 = 7'h2A;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        enable = 1'b1;
        k = -1;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < nvec; i++) begin
            while (k < vecs[i].k) step();
            check_out(tag, vecs[i].col, vecs[i].rws, vecs[i].tick, vecs[i].pg);
            level_col_0 = vecs[i].lvl0;
            alert_req   = vecs[i].areq;
        end
    endtask

    initial begin
        // A: basic scan timing, blanking, snapshot hold
        start(1'b0);
        check_out("reset", 5'b11111, 7'h7F, 1'b0, 1'b0);
        vecs[0]  = '{1,  7'h3E, 1'b0, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[1]  = '{2,  7'h3E, 1'b0, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[2]  = '{3,  7'h3E, 1'b0, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[3]  = '{8,  7'h3E, 1'b0, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[4]  = '{9,  7'h3E, 1'b0, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[5]  = '{10, 7'h3E, 1'b0, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[6]  = '{11, 7'h3E, 1'b0, 5'b11101, 7'h3E, 1'b0, 1'b0};
        vecs[7]  = '{19, 7'h00, 1'b0, 5'b11011, 7'h3E, 1'b0, 1'b0};
        vecs[8]  = '{27, 7'h00, 1'b0, 5'b10111, 7'h3E, 1'b0, 1'b0};
        vecs[9]  = '{35, 7'h00, 1'b0, 5'b01111, 7'h01, 1'b0, 1'b0};
        vecs[10] = '{40, 7'h00, 1'b0, 5'b01111, 7'h01, 1'b1, 1'b0};
        vecs[11] = '{41, 7'h00, 1'b0, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[12] = '{43, 7'h00, 1'b0, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[13] = '{51, 7'h00, 1'b0, 5'b11101, 7'h00, 1'b0, 1'b0};
        vecs[14] = '{80, 7'h00, 1'b0, 5'b01111, 7'h01, 1'b1, 1'b0};
        nvec = 15;
        run_vecs("scan");
        check("tick_count", 32'(ticks), 32'd2);

        // B: alert onset, alternation every PT frames, release, pulse ignored
        start(1'b1);
        vecs[0]  = '{3,   7'h3E, 1'b1, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[1]  = '{40,  7'h3E, 1'b1, 5'b01111, 7'h01, 1'b1, 1'b1};
        vecs[2]  = '{43,  7'h3E, 1'b1, 5'b11110, 7'h55, 1'b0, 1'b1};
        vecs[3]  = '{51,  7'h3E, 1'b1, 5'b11101, 7'h2A, 1'b0, 1'b1};
        vecs[4]  = '{83,  7'h3E, 1'b1, 5'b11110, 7'h55, 1'b0, 1'b1};
        vecs[5]  = '{120, 7'h3E, 1'b1, 5'b01111, 7'h55, 1'b1, 1'b0};
        vecs[6]  = '{123, 7'h3E, 1'b1, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[7]  = '{163, 7'h3E, 1'b1, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[8]  = '{203, 7'h3E, 1'b0, 5'b11110, 7'h55, 1'b0, 1'b1};
        vecs[9]  = '{240, 7'h3E, 1'b0, 5'b01111, 7'h55, 1'b1, 1'b0};
        vecs[10] = '{243, 7'h3E, 1'b0, 5'b11110, 7'h01, 1'b0, 1'b0};
        vecs[11] = '{250, 7'h3E, 1'b1, 5'b11111, 7'h7F, 1'b0, 1'b0};
        vecs[12] = '{260, 7'h3E, 1'b0, 5'b11011, 7'h3E, 1'b0, 1'b0};
        vecs[13] = '{283, 7'h3E, 1'b0, 5'b11110, 7'h01, 1'b0, 1'b0};
        nvec = 14;
        run_vecs("alert");

        // C: enable dropped at idx=3,cnt=5 on the alert page, then re-enable
        start(1'b1);
        while (k < 69) step();
        check_out("pre_dis", 5'b10111, 7'h2A, 1'b0, 1'b1);
        enable = 1'b0;
        step();
        check_out("dis", 5'b11111, 7'h7F, 1'b0, 1'b0);
        step();
        enable = 1'b1;
        alert_req = 1'b0;
        step();
        step();
        check_out("reen_blank", 5'b11111, 7'h7F, 1'b0, 1'b0);
        step();
        step();
        check_out("reen_col0", 5'b11110, 7'h01, 1'b0, 1'b0);

        // D: asynchronous reset between edges while driving
        start(1'b1);
        while (k < 45) step();
        check_out("pre_rst", 5'b11110, 7'h55, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 5'b11111, 7'h7F, 1'b0, 1'b0);
        @(negedge clk);
        check_out("rst_hold", 5'b11111, 7'h7F, 1'b0, 1'b0);
        enable = 1'b0;
        rst = 1'b0;
        step();
        check_out("post_rst", 5'b11111, 7'h7F, 1'b0, 1'b0);

`ifdef BRIGHTNESS_PWM_EN
        // E: brightness window, sampled once per frame
        brightness = 2'd0;
        start(1'b0);
        while (k < 3) step();
        check_out("pwm0_on", 5'b11110, 7'h01, 1'b0, 1'b0);
        step();
        check_out("pwm0_off", 5'b11111, 7'h7F, 1'b0, 1'b0);
        brightness = 2'd3;
        while (k < 12) step();
        check_out("pwm_hold", 5'b11111, 7'h7F, 1'b0, 1'b0);
        while (k < 48) step();
        check_out("pwm3_on", 5'b11110, 7'h01, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
